// File: rtl/fetch_queue_if.sv
// Handshake bundle between instruction fetch, the fetch queue and decode.
// master: the fetch/decode side that drives pushes, pops and flush.
// slave : the fetch queue itself.
interface fetch_queue_if #(
    parameter int PTR_W = 2
);
    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic             out_ready;
    logic             flush;
    logic [PTR_W:0]   count;

    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO of {pc, inst} pairs between instruction memory and
// decode. Flush discards everything (including the incoming pair) and has
// priority over push/pop. Asynchronous active-high reset clears pointers,
// occupancy and storage.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an
// incoming pair is presented to decode in the same cycle and, if decode takes
// it, is never written into storage.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [63:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             not_empty;
    logic             push;
    logic             pop;
    logic             byp_take;
    logic [63:0]      head;

    assign bus.in_ready = (count_q != FULL_CNT);
    assign bus.count    = count_q;

    // Head presentation and handshake qualification (bypass optional).
    always_comb begin
        not_empty = (count_q != '0);
        head      = mem_q[rd_ptr_q];
        byp_take  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (not_empty) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = head[63:32];
            bus.out_inst  = head[31:0];
        end else if (bus.in_valid && !bus.flush) begin
            // Empty queue: forward the incoming pair straight to decode.
            bus.out_valid = 1'b1;
            bus.out_pc    = bus.in_pc;
            bus.out_inst  = bus.in_inst;
            byp_take      = bus.out_ready;
        end else begin
            bus.out_valid = 1'b0;
            bus.out_pc    = '0;
            bus.out_inst  = '0;
        end
`else
        bus.out_valid = not_empty;
        bus.out_pc    = not_empty ? head[63:32] : 32'h0;
        bus.out_inst  = not_empty ? head[31:0]  : 32'h0;
`endif
        // A bypassed pair consumed by decode is not also stored.
        push = bus.in_valid && bus.in_ready && !bus.flush && !byp_take;
        pop  = not_empty && bus.out_ready && !bus.flush;
    end

    // Next-state for storage, pointers and occupancy; flush wins over all.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {bus.in_pc, bus.in_inst};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous clear of everything, storage included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule
